// File: rtl/instr_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and instruction memory (slave).
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/instr_fetch.sv
// Program-counter register and instruction-fetch sequencer: fetches the word at
// PCout, presents it to decode, then advances to the branch unit's PCnext.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          PCnext,
    input  logic                 pc_load,
    input  logic                 halt,
    instr_fetch_if.master        imem,
    output logic [31:0]          PCout,
    output logic [31:0]          instr,
    output logic                 instr_valid,
    output logic                 halted,
    output logic                 fault,
    output logic [1:0]           fault_code
);

    localparam int unsigned   TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        START,
        FETCH,
        HOLD,
        HALTED,
        FAULT
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] timer;
    logic          timeout_hit;
    logic          misaligned;
    logic          advance;

    // The ack on the last permitted cycle wins over the timeout.
    always_comb begin
        timeout_hit = (TIMEOUT > 0) && !imem.imem_ack && (timer == TLAST);
        misaligned  = (PCnext[1:0] != 2'b00);
        advance     = (state == HOLD) && !halt && pc_load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= START;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            START: state_nx = FETCH;
            FETCH: begin
                if (imem.imem_ack) begin
                    state_nx = HOLD;
                end else if (timeout_hit) begin
                    state_nx = FAULT;
                end
            end
            HOLD: begin
                if (halt) begin
                    state_nx = HALTED;
                end else if (pc_load) begin
                    state_nx = misaligned ? FAULT : FETCH;
                end
            end
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PCout      <= RESET_PC;
            instr      <= '0;
            fault_code <= '0;
            timer      <= '0;
        end else begin
            timer <= ((state == FETCH) && !imem.imem_ack) ? timer + TW'(1) : '0;
            if ((state == FETCH) && imem.imem_ack) begin
                instr <= imem.imem_data;
            end
            if ((state == FETCH) && timeout_hit) begin
                fault_code <= 2'b01;
            end
            if (advance) begin
                if (misaligned) begin
                    fault_code <= 2'b10;
                end else begin
                    PCout <= PCnext;
                end
            end
        end
    end

    // Status outputs are decoded from the state register only, so they carry
    // no combinational path from the inputs.
    always_comb begin
        imem.imem_req  = (state == FETCH);
        imem.imem_addr = PCout;
        instr_valid    = (state == HOLD);
        halted         = (state == HALTED);
        fault          = (state == FAULT);
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized bench for instr_fetch with an instruction-memory
// model driven from the bench and a PC/instruction reference model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCnext;
    logic        pc_load;
    logic        halt;
    logic [31:0] PCout;
    logic [31:0] instr;
    logic        instr_valid;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_code;

    instr_fetch_if bus ();

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PCnext      (PCnext),
        .pc_load     (pc_load),
        .halt        (halt),
        .imem        (bus.master),
        .PCout       (PCout),
        .instr       (instr),
        .instr_valid (instr_valid),
        .halted      (halted),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] m_pc;
    logic [31:0] m_instr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_hold(input string tag);
        check({tag, "_pc"},     PCout,        m_pc);
        check({tag, "_valid"},  instr_valid,  32'd1);
        check({tag, "_instr"},  instr,        m_instr);
        check({tag, "_req"},    bus.imem_req, 32'd0);
        check({tag, "_halted"}, halted,       32'd0);
        check({tag, "_fault"},  fault,        32'd0);
        check({tag, "_code"},   fault_code,   32'd0);
    endtask

    // Entered at the negedge of the first FETCH cycle; acks on cycle lat+1.
    task automatic fetch(input int unsigned lat, input logic [31:0] d);
        for (int unsigned i = 0; i <= lat; i++) begin
            if (i > 0) @(negedge clk);
            check("fetch_req",   bus.imem_req,  32'd1);
            check("fetch_addr",  bus.imem_addr, m_pc);
            check("fetch_valid", instr_valid,   32'd0);
        end
        bus.imem_ack  = 1'b1;
        bus.imem_data = d;
        @(negedge clk);
        bus.imem_ack  = 1'b0;
        bus.imem_data = $urandom;
        m_instr = d;
        check_hold("fetched");
    endtask

    task automatic load(input logic [31:0] t);
        PCnext  = t;
        pc_load = 1'b1;
        @(negedge clk);
        pc_load = 1'b0;
        PCnext  = $urandom;
    endtask

    // Stay in HOLD with stray acks and junk PCnext, which must all be ignored.
    task automatic idle_hold(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            bus.imem_ack  = 1'($urandom_range(0, 1));
            bus.imem_data = $urandom;
            PCnext        = $urandom;
            @(negedge clk);
            check_hold("idle");
        end
        bus.imem_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_pc    = 32'h0;
        m_instr = 32'h0;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] t;
        int unsigned sel;

        rst           = 1'b1;
        pc_load       = 1'b0;
        halt          = 1'b0;
        PCnext        = '0;
        bus.imem_ack  = 1'b0;
        bus.imem_data = '0;
        repeat (2) @(negedge clk);
        check("rst_pc",     PCout,        32'h0);
        check("rst_instr",  instr,        32'h0);
        check("rst_valid",  instr_valid,  32'd0);
        check("rst_req",    bus.imem_req, 32'd0);
        check("rst_halted", halted,       32'd0);
        check("rst_fault",  fault,        32'd0);
        check("rst_code",   fault_code,   32'd0);

        // First fetch: req one cycle after release, valid on the third cycle.
        rst = 1'b0;
        @(negedge clk);
        m_pc = 32'h0;
        fetch(1, 32'h1234_5678);

        load(32'h4);
        m_pc = 32'h4;
        fetch(0, $urandom);
        idle_hold(2);
        load(32'h40);
        m_pc = 32'h40;
        fetch(3, $urandom);

        for (int k = 0; k < 24; k++) begin
            idle_hold($urandom_range(0, 3));
            r   = $urandom;
            t   = {r[31:2], 2'b00};
            sel = $urandom_range(0, 7);
            if (sel == 0) t = 32'hFFFF_FFFC;
            if (sel == 1) t = m_pc + 32'd4;
            load(t);
            m_pc = t;
            fetch($urandom_range(0, 15), $urandom);
        end

        // Sequential wrap from the top of the address space.
        load(32'hFFFF_FFFC);
        m_pc = 32'hFFFF_FFFC;
        fetch(1, $urandom);
        load(m_pc + 32'd4);
        m_pc = 32'h0;
        fetch(2, $urandom);

        // Halt during FETCH is ignored; it only counts while in HOLD.
        load(32'h100);
        m_pc = 32'h100;
        halt = 1'b1;
        fetch(2, $urandom);
        halt = 1'b0;
        @(negedge clk);
        check_hold("halt_dropped");
        halt    = 1'b1;
        pc_load = 1'b1;
        PCnext  = 32'h200;
        @(negedge clk);
        pc_load = 1'b0;
        check("halt_halted", halted,       32'd1);
        check("halt_pc",     PCout,        m_pc);
        check("halt_valid",  instr_valid,  32'd0);
        check("halt_req",    bus.imem_req, 32'd0);
        check("halt_fault",  fault,        32'd0);
        halt = 1'b0;
        load(32'h300);
        bus.imem_ack = 1'b1;
        repeat (2) @(negedge clk);
        bus.imem_ack = 1'b0;
        check("halted_sticky", halted,       32'd1);
        check("halted_pc",     PCout,        m_pc);
        check("halted_req",    bus.imem_req, 32'd0);

        // Misaligned target.
        do_reset();
        fetch(0, $urandom);
        idle_hold(1);
        load(32'h0000_0006);
        check("mis_fault", fault,        32'd1);
        check("mis_code",  fault_code,   32'd2);
        check("mis_pc",    PCout,        m_pc);
        check("mis_req",   bus.imem_req, 32'd0);
        check("mis_valid", instr_valid,  32'd0);
        load(32'h8);
        repeat (2) @(negedge clk);
        check("mis_sticky_pc",  PCout,        m_pc);
        check("mis_sticky_req", bus.imem_req, 32'd0);
        check("mis_sticky_code", fault_code,  32'd2);

        // Timeout: 16 request cycles without ack.
        do_reset();
        fetch(0, $urandom);
        load(32'h300);
        m_pc = 32'h300;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            check("to_req",   bus.imem_req, 32'd1);
            check("to_fault", fault,        32'd0);
        end
        @(negedge clk);
        check("to_fault_set", fault,        32'd1);
        check("to_code",      fault_code,   32'd1);
        check("to_req_low",   bus.imem_req, 32'd0);
        check("to_pc",        PCout,        32'h300);
        bus.imem_ack  = 1'b1;
        bus.imem_data = $urandom;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        @(negedge clk);
        check("to_late_ack_fault", fault,       32'd1);
        check("to_late_ack_instr", instr,       m_instr);
        check("to_late_ack_valid", instr_valid, 32'd0);

        // Ack on exactly the 16th cycle is accepted.
        do_reset();
        fetch(15, $urandom);
        load(32'h80);
        m_pc = 32'h80;
        fetch(15, $urandom);

        // Asynchronous reset in the middle of a fetch; in-flight ack ignored.
        load(32'h80);
        check("mid_req",  bus.imem_req,  32'd1);
        check("mid_addr", bus.imem_addr, 32'h80);
        #2 rst = 1'b1;
        #1;
        check("async_req",   bus.imem_req, 32'd0);
        check("async_pc",    PCout,        32'h0);
        check("async_instr", instr,        32'h0);
        check("async_valid", instr_valid,  32'd0);
        bus.imem_ack  = 1'b1;
        bus.imem_data = 32'hDEAD_BEEF;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        check("restart_instr", instr, 32'h0);
        m_pc = 32'h0;
        fetch(1, $urandom);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
